// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the arbiter slice.
//   htrans_t    - HTRANS transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   arb_state_t - arbiter ownership states (no owner, master 0, master 1)
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_OWN0 = 2'b01,
        ARB_OWN1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/arb_hold_counter.sv
// arb_hold_counter: saturating 8-bit counter with clear, enable and limit.
//   HCLK   - clock, rising edge
//   HRESET - synchronous active-high reset (count -> 0)
//   clr    - synchronous clear, wins over enable
//   en     - count up by one, stops once count reaches limit
//   limit  - saturation value
//   count  - current count
module arb_hold_counter (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] limit,
    output logic [7:0] count
);

    always_ff @(posedge HCLK) begin
        if (HRESET || clr)
            count <= '0;
        else if (en && count < limit)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/ahblite_arbiter.sv
// ahblite_arbiter: two-master AHB-Lite bus arbiter (M0 = CPU, M1 = DMA).
//   HCLK      - clock, all state on rising edge
//   HRESET    - synchronous active-high reset
//   HREADY    - bus ready; state only advances when high
//   HTRANS    - transfer type of the current address phase
//   REQ[1:0]  - level-sensitive bus requests
//   LOCK[1:0] - per-master lock request, honoured for the owner only
//   GRANT     - one-hot-or-zero address-phase grant
//   ADDR_SEL  - address-phase master select (0 when no owner)
//   DATA_SEL  - data-phase master select, ADDR_SEL one accepted phase later
//   HMASTLOCK - lock bit of the current owner
// Build option: define ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// in favour of the master that did not own the bus most recently; otherwise
// M0 has fixed priority over M1.
import ahb_pkg::*;

module ahblite_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic [1:0] REQ,
    input  logic [1:0] LOCK,
    output logic [1:0] GRANT,
    output logic       ADDR_SEL,
    output logic       DATA_SEL,
    output logic       HMASTLOCK
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);

    arb_state_t state, state_nxt;
    logic [7:0] hold_cnt;
    logic       rearb, hold_expired, pick1, cnt_clr, cnt_en;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_eff;
    // The live owner is the most recent owner; in IDLE fall back to the register.
    assign last_eff = (state == ARB_OWN0) ? 1'b0 : (state == ARB_OWN1) ? 1'b1 : last_q;
    always_ff @(posedge HCLK) begin
        last_q <= HRESET ? 1'b1 : last_eff;
    end
`endif

    always_comb begin
        GRANT     = {state == ARB_OWN1, state == ARB_OWN0};
        ADDR_SEL  = (state == ARB_OWN1);
        HMASTLOCK = (state == ARB_OWN0) ? LOCK[0] : (state == ARB_OWN1) ? LOCK[1] : 1'b0;
        rearb     = HREADY && (HTRANS == HTRANS_IDLE || HTRANS == HTRANS_NONSEQ) && !HMASTLOCK;
        // The count covers completed cycles, so this cycle is the MAX_HOLD-th one.
        hold_expired = (hold_cnt >= HOLD_LAST);
`ifdef ARB_ROUND_ROBIN_EN
        pick1 = !last_eff;
`else
        pick1 = 1'b0;
`endif
        // An owner past its hold budget yields to a contending master.
        if (state == ARB_OWN0 && hold_expired)
            pick1 = 1'b1;
        else if (state == ARB_OWN1 && hold_expired)
            pick1 = 1'b0;
        state_nxt = state;
        if (rearb)
            state_nxt = (REQ == 2'b00) ? ARB_IDLE :
                        (REQ == 2'b01) ? ARB_OWN0 :
                        (REQ == 2'b10) ? ARB_OWN1 :
                        pick1 ? ARB_OWN1 : ARB_OWN0;
        cnt_clr = (state_nxt != state) || (state_nxt == ARB_IDLE);
        cnt_en  = HREADY && (state != ARB_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ARB_IDLE;
            DATA_SEL <= 1'b0;
        end else begin
            state <= state_nxt;
            if (HREADY)
                DATA_SEL <= ADDR_SEL;
        end
    end

    arb_hold_counter u_hold (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (HOLD_LIMIT),
        .count  (hold_cnt)
    );

endmodule

// File: tb/tb_ahblite_arbiter.sv
// tb_ahblite_arbiter: directed table plus corner-case sequences for ahblite_arbiter (MAX_HOLD=4).
module tb_ahblite_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESET, HREADY, ADDR_SEL, DATA_SEL, HMASTLOCK;
    logic [1:0] HTRANS, REQ, LOCK, GRANT;
    int         n_cmp = 0;
    int         n_bad = 0;

    localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    always #5 HCLK = ~HCLK;

    ahblite_arbiter #(.MAX_HOLD(4)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .REQ       (REQ),
        .LOCK      (LOCK),
        .GRANT     (GRANT),
        .ADDR_SEL  (ADDR_SEL),
        .DATA_SEL  (DATA_SEL),
        .HMASTLOCK (HMASTLOCK)
    );

    typedef struct {
        logic       rst;
        logic       hr;
        logic [1:0] tr;
        logic [1:0] req;
        logic [1:0] lock;
        logic [1:0] g;
        logic       a;
        logic       d;
        logic       l;
    } vec_t;

    vec_t v[19];

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic hr, input logic [1:0] tr,
                         input logic [1:0] req, input logic [1:0] lock);
        HRESET = rst; HREADY = hr; HTRANS = tr; REQ = req; LOCK = lock;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int cyc;
        HRESET = 1'b1; HREADY = 1'b1; HTRANS = T_IDLE; REQ = 2'b00; LOCK = 2'b00;
        //          rst hr tr      req    lock   grant  a  d  l
        v[0]  = '{1'b1, 1'b1, T_IDLE, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        v[1]  = '{1'b0, 1'b1, T_IDLE, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
        v[2]  = '{1'b0, 1'b1, T_NSEQ, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
        v[3]  = '{1'b0, 1'b1, T_NSEQ, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        v[4]  = '{1'b0, 1'b1, T_SEQ,  2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
        v[5]  = '{1'b0, 1'b0, T_NSEQ, 2'b01, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
        v[6]  = '{1'b0, 1'b0, T_NSEQ, 2'b01, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
        v[7]  = '{1'b0, 1'b0, T_NSEQ, 2'b01, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
        v[8]  = '{1'b0, 1'b1, T_NSEQ, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
        v[9]  = '{1'b0, 1'b1, T_NSEQ, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
        v[10] = '{1'b0, 1'b1, T_IDLE, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        v[11] = '{1'b0, 1'b1, T_IDLE, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        v[12] = '{1'b0, 1'b1, T_NSEQ, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1};
        v[13] = '{1'b0, 1'b1, T_NSEQ, 2'b01, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1};
        v[14] = '{1'b0, 1'b1, T_NSEQ, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
        v[15] = '{1'b0, 1'b1, T_NSEQ, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        v[16] = '{1'b0, 1'b1, T_SEQ,  2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1};
        v[17] = '{1'b1, 1'b1, T_SEQ,  2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        v[18] = '{1'b0, 1'b1, T_IDLE, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 19; i++) begin
            drive(v[i].rst, v[i].hr, v[i].tr, v[i].req, v[i].lock);
            chk($sformatf("vec%0d.grant", i), GRANT, v[i].g);
            chk($sformatf("vec%0d.addr_sel", i), {1'b0, ADDR_SEL}, {1'b0, v[i].a});
            chk($sformatf("vec%0d.data_sel", i), {1'b0, DATA_SEL}, {1'b0, v[i].d});
            chk($sformatf("vec%0d.hmastlock", i), {1'b0, HMASTLOCK}, {1'b0, v[i].l});
        end

        // Burst protection: M1 holds through SEQ beats, M0 wins at the NONSEQ.
        drive(1'b1, 1'b1, T_IDLE, 2'b00, 2'b00);
        drive(1'b0, 1'b1, T_IDLE, 2'b10, 2'b00);
        chk("burst.m1_owns", GRANT, 2'b10);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, T_SEQ, 2'b11, 2'b00);
            chk($sformatf("burst.seq%0d", i), GRANT, 2'b10);
        end
        drive(1'b0, 1'b1, T_NSEQ, 2'b11, 2'b00);
        chk("burst.handover", GRANT, 2'b01);

        // Pipeline: handover M0->M1, DATA_SEL follows only on an HREADY cycle.
        drive(1'b0, 1'b1, T_NSEQ, 2'b01, 2'b00);
        drive(1'b0, 1'b1, T_NSEQ, 2'b10, 2'b00);
        chk("pipe.addr_sel", {1'b0, ADDR_SEL}, 2'b01);
        chk("pipe.data_sel_n1", {1'b0, DATA_SEL}, 2'b00);
        drive(1'b0, 1'b0, T_NSEQ, 2'b10, 2'b00);
        chk("pipe.data_sel_wait", {1'b0, DATA_SEL}, 2'b00);
        drive(1'b0, 1'b1, T_NSEQ, 2'b10, 2'b00);
        chk("pipe.data_sel_ready", {1'b0, DATA_SEL}, 2'b01);

`ifndef ARB_ROUND_ROBIN_EN
        // Hold limit: M0 keeps the bus for exactly 4 cycles against M1.
        drive(1'b1, 1'b1, T_IDLE, 2'b00, 2'b00);
        drive(1'b0, 1'b1, T_IDLE, 2'b01, 2'b00);
        cyc = 1;
        while (GRANT == 2'b01 && cyc < 20) begin
            drive(1'b0, 1'b1, T_NSEQ, 2'b11, 2'b00);
            if (GRANT == 2'b01) cyc++;
        end
        chk("hold.cycles_owned", cyc[1:0], 2'd0);
        chk("hold.cycles_owned_hi", {1'b0, cyc == 4}, 2'b01);
        chk("hold.handover", GRANT, 2'b10);

        // Locked sequence overrides the hold limit until LOCK drops.
        drive(1'b1, 1'b1, T_IDLE, 2'b00, 2'b00);
        drive(1'b0, 1'b1, T_IDLE, 2'b01, 2'b00);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, T_NSEQ, 2'b11, 2'b01);
            chk($sformatf("lock.hold%0d", i), GRANT, 2'b01);
        end
        chk("lock.hmastlock", {1'b0, HMASTLOCK}, 2'b01);
        drive(1'b0, 1'b1, T_NSEQ, 2'b11, 2'b00);
        chk("lock.release", GRANT, 2'b10);
`endif

        // Continuous dual request with NONSEQ singles.
        drive(1'b1, 1'b1, T_IDLE, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, T_NSEQ, 2'b11, 2'b00);
`ifdef ARB_ROUND_ROBIN_EN
            chk($sformatf("both.grant%0d", i), GRANT, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
            chk($sformatf("both.grant%0d", i), GRANT, 2'b01);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
